// File: rtl/mult_div_ctrl.sv
// Iterative signed MULT/DIV sequencer for the HI/LO unit.
// Uses radix-2 Booth for multiply and restoring division on magnitudes for divide.
module mult_div_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic              div0,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, RUN, FIN, ZERO} state_t;

    state_t state, state_next;

    logic [CNT_W-1:0]  counter;
    logic              op_q;
    logic              neg_q;
    logic              neg_r;
    logic              q_m1;
    logic [DATA_W:0]   acc;
    logic [DATA_W:0]   mcand;
    logic [DATA_W-1:0] mplr;

    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;
    logic [DATA_W:0]   booth_sum;
    logic [DATA_W:0]   rem_shift;
    logic [DATA_W:0]   rem_diff;

    // Negating the most negative value wraps back to itself, which is the correct unsigned magnitude.
    assign a_mag = a[DATA_W-1] ? -a : a;
    assign b_mag = b[DATA_W-1] ? -b : b;

    // acc is one bit wider than an operand so Booth's add of -2^31 cannot overflow.
    always_comb begin
        booth_sum = acc;
        case ({mplr[0], q_m1})
            2'b01:   booth_sum = acc + mcand;
            2'b10:   booth_sum = acc - mcand;
            default: booth_sum = acc;
        endcase
    end

    assign rem_shift = {acc[DATA_W-1:0], mplr[DATA_W-1]};
    assign rem_diff  = rem_shift - mcand;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (op && (b == '0)) ? ZERO : RUN;
                end
            end
            RUN: begin
                if (counter == CNT_W'(DATA_W - 1)) begin
                    state_next = FIN;
                end
            end
            FIN:     state_next = IDLE;
            ZERO:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter <= '0;
            op_q    <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            q_m1    <= 1'b0;
            acc     <= '0;
            mcand   <= '0;
            mplr    <= '0;
            done    <= 1'b0;
            div0    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
            div0 <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        counter <= '0;
                        op_q    <= op;
                        neg_q   <= a[DATA_W-1] ^ b[DATA_W-1];
                        neg_r   <= a[DATA_W-1];
                        q_m1    <= 1'b0;
                        acc     <= '0;
                        if (op) begin
                            mcand <= {1'b0, b_mag};
                            mplr  <= a_mag;
                        end else begin
                            mcand <= {a[DATA_W-1], a};
                            mplr  <= b;
                        end
                    end
                end
                RUN: begin
                    counter <= counter + 1'b1;
                    if (!op_q) begin
                        {acc, mplr, q_m1} <= {booth_sum[DATA_W], booth_sum, mplr};
                    end else if (rem_diff[DATA_W]) begin
                        acc  <= rem_shift;
                        mplr <= {mplr[DATA_W-2:0], 1'b0};
                    end else begin
                        acc  <= rem_diff;
                        mplr <= {mplr[DATA_W-2:0], 1'b1};
                    end
                end
                FIN: begin
                    done <= 1'b1;
                    if (!op_q) begin
                        hi <= acc[DATA_W-1:0];
                        lo <= mplr;
                    end else begin
                        hi <= neg_r ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
                        lo <= neg_q ? -mplr : mplr;
                    end
                end
                ZERO: begin
                    div0 <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Testbench for mult_div_ctrl: directed vector table, random ops against an arithmetic model,
// plus hand sequences for ignored start and mid-operation reset.
module tb_mult_div_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic        div0;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int failures = 0;
    logic [63:0] ref_hilo = '0;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[11];

    mult_div_ctrl #(.DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .div0  (div0),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Signed arithmetic reference: SV division truncates toward zero and % follows the dividend sign.
    function automatic logic [63:0] ref_model(input logic o, input logic [31:0] x, input logic [31:0] y,
                                              input logic [63:0] prev);
        longint sx;
        longint sy;
        longint p;
        longint q;
        longint r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!o) begin
            p = sx * sy;
            return 64'(p);
        end
        if (y == 32'd0) return prev;
        q = sx / sy;
        r = sx % sy;
        return {32'(r), 32'(q)};
    endfunction

    // Issues one op starting at the current (negedge) time and follows it to done or div0.
    task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                          input logic [63:0] exp, input string tag, input int intrude_at);
        int          lat;
        int          busy_cnt;
        logic        hold_ok;
        logic        is_zero;
        logic [31:0] hold_hi;
        logic [31:0] hold_lo;
        hold_hi = hi;
        hold_lo = lo;
        is_zero = o && (y == 32'd0);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
        op = 1'($urandom);
        a = $urandom;
        b = $urandom;
        lat = 1;
        busy_cnt = 0;
        hold_ok = 1'b1;
        while (!(done || div0) && lat < 60) begin
            if (busy) busy_cnt++;
            if (hi !== hold_hi || lo !== hold_lo) hold_ok = 1'b0;
            if (lat == intrude_at) begin
                start = 1'b1;
                op = 1'b1;
                b = '0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check({tag, " latency"}, 64'(lat), is_zero ? 64'd2 : 64'd34);
        check({tag, " busy_cycles"}, 64'(busy_cnt), is_zero ? 64'd1 : 64'd33);
        check({tag, " busy_at_end"}, 64'(busy), 64'd0);
        check({tag, " done_div0"}, 64'({done, div0}), is_zero ? 64'd1 : 64'd2);
        check({tag, " hold_during_run"}, 64'(hold_ok), 64'd1);
        check({tag, " hi_lo"}, {hi, lo}, exp);
    endtask

    initial begin
        int          quiet_done;
        int          quiet_busy;
        logic        o;
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] exp;

        vecs[0]  = '{1'b0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1]  = '{1'b0, 32'h80000000,   32'h80000000, 32'h40000000, 32'h00000000};
        vecs[2]  = '{1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{1'b1, 32'd7,          32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[4]  = '{1'b0, 32'h11,         32'h2,        32'h00000000, 32'h00000022};
        vecs[5]  = '{1'b1, 32'd5,          32'd0,        32'h00000000, 32'h00000022};
        vecs[6]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[7]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[8]  = '{1'b0, 32'h7FFFFFFF,   32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
        vecs[9]  = '{1'b1, 32'd100,        32'd7,        32'h00000002, 32'h0000000E};
        vecs[10] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E};

        repeat (2) @(negedge clk);
        check("reset_outputs", {27'd0, busy, done, div0, 2'd0, hi[31:16]}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Table runs back to back: each start is issued in the previous op's done cycle.
        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo},
                   $sformatf("vec%0d", i), 0);
            ref_hilo = {vecs[i].hi, vecs[i].lo};
        end

        @(negedge clk);
        exp = ref_model(1'b0, 32'd7, 32'hFFFFFFFD, ref_hilo);
        run_op(1'b0, 32'd7, 32'hFFFFFFFD, exp, "ignored_start", 10);
        ref_hilo = exp;
        check("ignored_start no_second_op", 64'(busy), 64'd0);

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            o = 1'($urandom);
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = '0;
                1: x = 32'h80000000;
                2: y = 32'hFFFFFFFF;
                3: y = {28'd0, 4'($urandom)};
                default: ;
            endcase
            exp = ref_model(o, x, y, ref_hilo);
            run_op(o, x, y, exp, $sformatf("rand%0d", i), 0);
            ref_hilo = exp;
        end

        @(negedge clk);
        start = 1'b1;
        op = 1'b0;
        a = 32'd3;
        b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check("pre_reset busy", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        check("mid_reset busy_done_div0", 64'({busy, done, div0}), 64'd0);
        check("mid_reset hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        quiet_done = 0;
        quiet_busy = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || div0) quiet_done++;
            if (busy) quiet_busy++;
        end
        check("post_reset no_done", 64'(quiet_done), 64'd0);
        check("post_reset idle", 64'(quiet_busy), 64'd0);
        ref_hilo = '0;

        exp = ref_model(1'b0, 32'd3, 32'd4, ref_hilo);
        run_op(1'b0, 32'd3, 32'd4, exp, "recover_mult", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
